// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared constants and types for the maze storage stage
//
// Purpose : default maze geometry, FSM state encoding, wall encoding and the
//           goal coordinate shared by maze_memory, maze_bitplane and the solver.
// Ports   : none (package).
package maze_pkg;

   localparam int MAZE_N    = 4;
   localparam int MAZE_SIZE = 1 << MAZE_N;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_READY = 2'd1,
      ST_CLEAR = 2'd2
   } maze_state_t;

   // A set bit in the wall map means the cell cannot be entered.
   localparam logic MAZE_WALL = 1'b1;

   // Goal cell is (SIZE-1, SIZE-1): both coordinates all-ones, which is the
   // same condition the datapath uses for "found".
   localparam logic [MAZE_N-1:0] MAZE_GOAL = '1;

endpackage

// File: rtl/maze_bitplane.sv
// rtl/maze_bitplane.sv - SIZE x SIZE bit array with row write, bit set and registered read
//
// Purpose : one bit per maze cell. Used once for walls and once for visited marks.
// Ports   : i_clk, i_rst        clock, asynchronous active-high reset (clears array)
//           i_clr_all           synchronous clear of every bit
//           i_row_we/_addr/_data write one full row (bit i = column i)
//           i_set_en/_x/_y      set a single bit
//           i_rd_en/_x/_y       read a single bit; result on o_rd_bit next cycle
//           o_rd_bit            registered read data, holds when i_rd_en is low
module maze_bitplane
   import maze_pkg::*;
#(
   parameter int N    = MAZE_N,
   parameter int SIZE = 1 << N
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_clr_all,
   input  logic            i_row_we,
   input  logic [N-1:0]    i_row_addr,
   input  logic [SIZE-1:0] i_row_data,
   input  logic            i_set_en,
   input  logic [N-1:0]    i_set_x,
   input  logic [N-1:0]    i_set_y,
   input  logic            i_rd_en,
   input  logic [N-1:0]    i_rd_x,
   input  logic [N-1:0]    i_rd_y,
   output logic            o_rd_bit
);

   logic [SIZE-1:0] r_mem [SIZE];
   logic            r_rd_bit;

   // The read samples the array before this edge's writes land, so a read
   // and a write to the same cell in one cycle return the old value.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int r = 0; r < SIZE; r++) begin
            r_mem[r] <= '0;
         end
         r_rd_bit <= 1'b0;
      end else begin
         if (i_clr_all) begin
            for (int r = 0; r < SIZE; r++) begin
               r_mem[r] <= '0;
            end
         end else begin
            if (i_row_we) begin
               r_mem[i_row_addr] <= i_row_data;
            end
            if (i_set_en) begin
               r_mem[i_set_y][i_set_x] <= 1'b1;
            end
         end
         if (i_rd_en) begin
            r_rd_bit <= r_mem[i_rd_y][i_rd_x];
         end
      end
   end

   assign o_rd_bit = r_rd_bit;

endmodule

// File: rtl/maze_memory.sv
// rtl/maze_memory.sv - maze wall map loader and blocked-cell query stage
//
// Purpose : holds the SIZE x SIZE wall map (loaded row by row over a
//           valid/ready handshake) and answers one-cycle-latency "is this
//           cell blocked?" queries for the solver. Visited-cell tracking is
//           built only when MAZE_VISITED_EN is defined; without it the
//           mark/clear ports stay in the interface but are ignored.
// Ports   : i_clk, i_rst            clock, asynchronous active-high reset
//           i_start_load            discard map, re-enter LOAD (highest priority)
//           i_load_valid/_row       row handshake input; o_load_ready accepts
//           o_load_done             all rows loaded, map usable
//           i_rd_en/_x/_y           query; o_rd_valid/o_rd_blocked next cycle
//           i_mark_en/_x/_y         mark a cell visited
//           i_clear_visited         erase all visited marks (one row per cycle)
//           o_busy                  in LOAD or CLEAR; queries ignored
module maze_memory
   import maze_pkg::*;
#(
   parameter int N    = MAZE_N,
   parameter int SIZE = 1 << N
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start_load,
   input  logic            i_load_valid,
   input  logic [SIZE-1:0] i_load_row,
   output logic            o_load_ready,
   output logic            o_load_done,
   input  logic            i_rd_en,
   input  logic [N-1:0]    i_rd_x,
   input  logic [N-1:0]    i_rd_y,
   output logic            o_rd_blocked,
   output logic            o_rd_valid,
   input  logic            i_mark_en,
   input  logic [N-1:0]    i_mark_x,
   input  logic [N-1:0]    i_mark_y,
   input  logic            i_clear_visited,
   output logic            o_busy
);

   localparam logic [N-1:0] ROW_LAST = '1;

   maze_state_t  r_state;
   maze_state_t  w_state_next;
   logic [N-1:0] r_row_cnt;
   logic [N-1:0] w_row_cnt_next;
   logic         r_rd_valid;
   logic         w_wall_we;
   logic         w_rd_go;
   logic         w_wall_bit;
   logic         w_vis_bit;

`ifdef MAZE_VISITED_EN
   logic         w_vis_clr_all;
   logic         w_vis_row_we;
   logic         w_mark_go;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_LOAD;
         r_row_cnt  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_row_cnt  <= w_row_cnt_next;
         r_rd_valid <= w_rd_go;
      end
   end

   // r_row_cnt is the row pointer in LOAD and the row being wiped in CLEAR.
   always_comb begin
      w_state_next   = r_state;
      w_row_cnt_next = r_row_cnt;
      w_wall_we      = 1'b0;
      w_rd_go        = 1'b0;
      o_load_ready   = 1'b0;
`ifdef MAZE_VISITED_EN
      w_vis_clr_all  = 1'b0;
      w_vis_row_we   = 1'b0;
      w_mark_go      = 1'b0;
`endif
      if (i_start_load) begin
         // Overrides everything, including a row offered in the same cycle.
         w_state_next   = ST_LOAD;
         w_row_cnt_next = '0;
`ifdef MAZE_VISITED_EN
         w_vis_clr_all  = 1'b1;
`endif
      end else begin
         case (r_state)
            ST_LOAD: begin
               o_load_ready = 1'b1;
               if (i_load_valid) begin
                  w_wall_we      = 1'b1;
                  w_row_cnt_next = r_row_cnt + 1'b1;
                  if (r_row_cnt == ROW_LAST) begin
                     w_state_next = ST_READY;
                  end
               end
            end
            ST_READY: begin
               w_rd_go = i_rd_en;
`ifdef MAZE_VISITED_EN
               w_mark_go = i_mark_en;
               if (i_clear_visited) begin
                  w_state_next   = ST_CLEAR;
                  w_row_cnt_next = '0;
               end
`endif
            end
            ST_CLEAR: begin
`ifdef MAZE_VISITED_EN
               w_vis_row_we = 1'b1;
`endif
               w_row_cnt_next = r_row_cnt + 1'b1;
               if (r_row_cnt == ROW_LAST) begin
                  w_state_next = ST_READY;
               end
            end
            default: begin
               w_state_next   = ST_LOAD;
               w_row_cnt_next = '0;
            end
         endcase
      end
   end

   maze_bitplane #(.N(N), .SIZE(SIZE)) u_wall (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr_all  (1'b0),
      .i_row_we   (w_wall_we),
      .i_row_addr (r_row_cnt),
      .i_row_data (i_load_row),
      .i_set_en   (1'b0),
      .i_set_x    ('0),
      .i_set_y    ('0),
      .i_rd_en    (w_rd_go),
      .i_rd_x     (i_rd_x),
      .i_rd_y     (i_rd_y),
      .o_rd_bit   (w_wall_bit)
   );

`ifdef MAZE_VISITED_EN
   maze_bitplane #(.N(N), .SIZE(SIZE)) u_visited (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr_all  (w_vis_clr_all),
      .i_row_we   (w_vis_row_we),
      .i_row_addr (r_row_cnt),
      .i_row_data ('0),
      .i_set_en   (w_mark_go),
      .i_set_x    (i_mark_x),
      .i_set_y    (i_mark_y),
      .i_rd_en    (w_rd_go),
      .i_rd_x     (i_rd_x),
      .i_rd_y     (i_rd_y),
      .o_rd_bit   (w_vis_bit)
   );
`else
   logic w_unused;
   assign w_vis_bit = 1'b0;
   assign w_unused  = &{1'b0, i_mark_en, i_mark_x, i_mark_y, i_clear_visited};
`endif

   assign o_rd_blocked = (w_wall_bit == MAZE_WALL) | w_vis_bit;
   assign o_rd_valid   = r_rd_valid;
   assign o_load_done  = (r_state != ST_LOAD);
   assign o_busy       = (r_state != ST_READY);

endmodule

// File: tb/tb_maze_memory.sv
// tb/tb_maze_memory.sv - directed self-checking bench for maze_memory
module tb_maze_memory;
   import maze_pkg::*;

`ifdef MAZE_VISITED_EN
   localparam bit VIS = 1'b1;
`else
   localparam bit VIS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_load = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_row = '0;
   logic        load_ready, load_done;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_x = '0, rd_y = '0;
   logic        rd_blocked, rd_valid;
   logic        mark_en = 1'b0;
   logic [3:0]  mark_x = '0, mark_y = '0;
   logic        clear_visited = 1'b0;
   logic        busy;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   maze_memory dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_start_load    (start_load),
      .i_load_valid    (load_valid),
      .i_load_row      (load_row),
      .o_load_ready    (load_ready),
      .o_load_done     (load_done),
      .i_rd_en         (rd_en),
      .i_rd_x          (rd_x),
      .i_rd_y          (rd_y),
      .o_rd_blocked    (rd_blocked),
      .o_rd_valid      (rd_valid),
      .i_mark_en       (mark_en),
      .i_mark_x        (mark_x),
      .i_mark_y        (mark_y),
      .i_clear_visited (clear_visited),
      .o_busy          (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 = loading, 1 = ready, 2 = clearing.
   logic [15:0] m_wall [16];
   logic [15:0] m_vis  [16];
   int          m_phase, m_rows, m_clr;
   logic        e_valid, e_blk;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 16; r++) begin
            m_wall[r] <= '0;
            m_vis[r]  <= '0;
         end
         m_phase <= 0;
         m_rows  <= 0;
         m_clr   <= 0;
         e_valid <= 1'b0;
         e_blk   <= 1'b0;
      end else if (start_load) begin
         for (int r = 0; r < 16; r++) m_vis[r] <= '0;
         m_phase <= 0;
         m_rows  <= 0;
         e_valid <= 1'b0;
      end else if (m_phase == 0) begin
         e_valid <= 1'b0;
         if (load_valid) begin
            m_wall[m_rows] <= load_row;
            m_rows <= m_rows + 1;
            if (m_rows + 1 == 16) m_phase <= 1;
         end
      end else if (m_phase == 1) begin
         e_valid <= rd_en;
         if (rd_en) e_blk <= m_wall[rd_y][rd_x] | (VIS & m_vis[rd_y][rd_x]);
         if (VIS && mark_en) m_vis[mark_y][mark_x] <= 1'b1;
         if (VIS && clear_visited) begin
            for (int r = 0; r < 16; r++) m_vis[r] <= '0;
            m_phase <= 2;
            m_clr   <= 16;
         end
      end else begin
         e_valid <= 1'b0;
         m_clr <= m_clr - 1;
         if (m_clr == 1) m_phase <= 1;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("load_ready", load_ready, (m_phase == 0) && !start_load);
         chk("load_done",  load_done,  m_phase != 0);
         chk("busy",       busy,       m_phase != 1);
         chk("rd_valid",   rd_valid,   e_valid);
         chk("rd_blocked", rd_blocked, e_blk);
      end
   end

   logic [15:0] map_rows [16];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_map(input logic [15:0] fill);
      for (int r = 0; r < 16; r++) map_rows[r] = fill;
   endtask

   task automatic load_map();
      load_valid = 1'b1;
      for (int r = 0; r < 16; r++) begin
         load_row = map_rows[r];
         tick();
         if (r == 14) chk("load_done_early", load_done, 1'b0);
      end
      load_valid = 1'b0;
      chk("load_done_rise", load_done, 1'b1);
   endtask

   task automatic pulse_start();
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
      chk("start_load_done", load_done, 1'b0);
   endtask

   task automatic query(input string nm, input int x, input int y, input logic want);
      rd_en = 1'b1;
      rd_x  = 4'(x);
      rd_y  = 4'(y);
      tick();
      rd_en = 1'b0;
      chk({nm, "_valid"}, rd_valid, 1'b1);
      chk(nm, rd_blocked, want);
   endtask

   initial begin
      int busy_cnt;
      #1 rst = 1'b1;
      chk_on = 1'b1;
      tick();
      tick();
      chk("rst_load_ready", load_ready, 1'b1);
      chk("rst_load_done",  load_done,  1'b0);
      chk("rst_busy",       busy,       1'b1);
      chk("rst_rd_valid",   rd_valid,   1'b0);
      chk("rst_rd_blocked", rd_blocked, 1'b0);
      rst = 1'b0;
      tick();

      // Empty map, query the goal.
      set_map(16'h0000);
      load_map();
      query("goal_empty", MAZE_GOAL, MAZE_GOAL, 1'b0);

      // Single wall at (5,3).
      pulse_start();
      set_map(16'h0000);
      map_rows[3] = 16'h0020;
      load_map();
      query("q_5_3", 5, 3, 1'b1);
      query("q_4_3", 4, 3, 1'b0);
      query("q_5_2", 5, 2, 1'b0);

      // Same-cycle read and mark returns the pre-mark value.
      rd_en = 1'b1; rd_x = 4'd2; rd_y = 4'd2;
      mark_en = 1'b1; mark_x = 4'd2; mark_y = 4'd2;
      tick();
      rd_en = 1'b0; mark_en = 1'b0;
      chk("mark_same_cycle", rd_blocked, 1'b0);
      query("mark_after", 2, 2, VIS);

      // Mark (1,1), then clear; reads held during the clear are ignored.
      mark_en = 1'b1; mark_x = 4'd1; mark_y = 4'd1;
      tick();
      mark_en = 1'b0;
      clear_visited = 1'b1;
      tick();
      clear_visited = 1'b0;
      rd_en = 1'b1; rd_x = 4'd1; rd_y = 4'd1;
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy) busy_cnt++;
         tick();
      end
      rd_en = 1'b0;
      chk("clear_busy_cycles", busy_cnt, VIS ? 16 : 0);
      query("after_clear_1_1", 1, 1, 1'b0);
      query("after_clear_2_2", 2, 2, 1'b0);

      // Random map, back-to-back sweep of every cell with random marks.
      pulse_start();
      for (int r = 0; r < 16; r++) map_rows[r] = 16'($urandom);
      load_map();
      for (int i = 0; i < 256; i++) begin
         rd_en   = 1'b1;
         rd_x    = i[3:0];
         rd_y    = i[7:4];
         mark_en = ($urandom_range(0, 3) == 0);
         mark_x  = 4'($urandom);
         mark_y  = 4'($urandom);
         tick();
      end
      mark_en = 1'b0;
      for (int i = 0; i < 64; i++) begin
         rd_x = 4'($urandom);
         rd_y = 4'($urandom);
         tick();
      end
      rd_en = 1'b0;

      // Reset part-way through a load.
      pulse_start();
      load_valid = 1'b1;
      load_row   = 16'hFFFF;
      repeat (7) tick();
      load_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midload_rst_done",  load_done,  1'b0);
      chk("midload_rst_ready", load_ready, 1'b1);
      tick();
      rst = 1'b0;
      tick();
      set_map(16'h0000);
      map_rows[10] = 16'h0400;
      load_map();
      query("old_row0",  0, 0, 1'b0);
      query("old_row6",  15, 6, 1'b0);
      query("new_10_10", 10, 10, 1'b1);
      query("new_9_10",  9, 10, 1'b0);

      // start_load part-way through a load restarts at row 0.
      pulse_start();
      load_valid = 1'b1;
      load_row   = 16'hFFFF;
      repeat (5) tick();
      load_valid = 1'b0;
      pulse_start();
      set_map(16'h0000);
      map_rows[0] = 16'h0001;
      load_map();
      query("restart_0_0", 0, 0, 1'b1);
      query("restart_0_4", 0, 4, 1'b0);

      // start_load wins over clear_visited and a read in READY.
      start_load = 1'b1; clear_visited = 1'b1;
      rd_en = 1'b1; rd_x = 4'd0; rd_y = 4'd0;
      tick();
      start_load = 1'b0; clear_visited = 1'b0;
      chk("prio_load_done", load_done, 1'b0);
      chk("prio_rd_valid",  rd_valid,  1'b0);
      chk("prio_busy",      busy,      1'b1);
      repeat (3) tick();
      chk("load_rd_valid", rd_valid, 1'b0);
      rd_en = 1'b0;
      set_map(16'h8000);
      load_map();
      query("final_goal", MAZE_GOAL, MAZE_GOAL, 1'b1);
      query("final_0_7",  0, 7, 1'b0);

      tick();
      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
